// File: rtl/crc5_check.sv
// Receive-side USB token CRC5 checker: shifts in {addr, endp, crc} MSB-first,
// runs the x^5+x^2+1 LFSR and compares the final value against the residual.
module crc5_check #(
    parameter logic [4:0] RESIDUAL   = 5'b01100,
    parameter int         NBITS_DATA = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       rec,
    output logic       busy,
    output logic       done,
    output logic       crc_ok,
    output logic [6:0] addr,
    output logic [3:0] endp,
    output logic [4:0] residual
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(NBITS_DATA - 1);
    localparam logic [3:0] LAST_CRC  = 4'd4;
    localparam logic [4:0] PRESET    = 5'b11111;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [4:0]              lfsr_q, lfsr_d;
    logic [NBITS_DATA-1:0]   field_q, field_d;
    logic [6:0]              addr_q, addr_d;
    logic [3:0]              endp_q, endp_d;
    logic [4:0]              residual_q, residual_d;
    logic                    crc_ok_q, crc_ok_d;
    logic [4:0]              lfsr_adv;
    logic                    fb;

    // One LFSR step for the bit on the wire this cycle; only used when consumed.
    assign fb       = lfsr_q[4] ^ bit_in;
    assign lfsr_adv = {lfsr_q[3], lfsr_q[2], lfsr_q[1] ^ fb, lfsr_q[0], fb};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        field_d    = field_q;
        addr_d     = addr_q;
        endp_d     = endp_q;
        residual_d = residual_q;
        crc_ok_d   = crc_ok_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    lfsr_d  = PRESET;
                    field_d = '0;
                end
            end
            DATA: begin
                if (start) begin
                    cnt_d   = '0;
                    lfsr_d  = PRESET;
                    field_d = '0;
                end else if (bit_valid) begin
                    lfsr_d  = lfsr_adv;
                    field_d = {field_q[NBITS_DATA-2:0], bit_in};
                    if (cnt_q == LAST_DATA) begin
                        state_d = CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            CRC: begin
                if (start) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    lfsr_d  = PRESET;
                    field_d = '0;
                end else if (bit_valid) begin
                    lfsr_d = lfsr_adv;
                    if (cnt_q == LAST_CRC) begin
                        // Result is captured from the post-update LFSR on the final bit.
                        state_d    = DONE;
                        cnt_d      = '0;
                        residual_d = lfsr_adv;
                        crc_ok_d   = (lfsr_adv == RESIDUAL);
                        addr_d     = field_q[10:4];
                        endp_d     = field_q[3:0];
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (rec && start) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    lfsr_d  = PRESET;
                    field_d = '0;
                end else if (rec) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lfsr_q     <= PRESET;
            field_q    <= '0;
            addr_q     <= '0;
            endp_q     <= '0;
            residual_q <= '0;
            crc_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            field_q    <= field_d;
            addr_q     <= addr_d;
            endp_q     <= endp_d;
            residual_q <= residual_d;
            crc_ok_q   <= crc_ok_d;
        end
    end

    assign busy     = (state_q == DATA) || (state_q == CRC);
    assign done     = (state_q == DONE);
    assign crc_ok   = crc_ok_q;
    assign addr     = addr_q;
    assign endp     = endp_q;
    assign residual = residual_q;

endmodule

// File: doc/crc5_check.md
Name: crc5_check

Overview:
- Receive-side counterpart of the token CRC5 generator.
- Accepts a 16-bit serial token field, MSB-first: 11 bits {addr[6:0], endp[3:0]}, then the 5 transmitted CRC bits (complemented remainder, MSB-first).
- Runs the same x^5+x^2+1 LFSR, preset 5'b11111, over all 16 bits.
- Reports pass/fail against the USB CRC5 residual 5'b01100, and presents the captured addr/endp to the token decoder with a done/rec handshake.

Parameters:
- RESIDUAL, 5'b01100, LFSR value after 16 bits that indicates a good CRC.
- NBITS_DATA, 11, number of field bits before the CRC bits; fixed at 11 for tokens.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  synchronous, active-high reset. The name follows codebase convention; asserted = 1.
- start  input  1  one-cycle pulse that begins a new check.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is consumed this cycle; gaps are allowed.
- rec  input  1  consumer acknowledge of the result.
- busy  output  1  a check is in progress (DATA or CRC state).
- done  output  1  result valid, held until rec.
- crc_ok  output  1  residual == RESIDUAL; valid while done.
- addr  output  7  captured field[10:4].
- endp  output  4  captured field[3:0].
- residual  output  5  final LFSR value {d4..d0}; valid while done.

Behaviour:
- LFSR bits d4..d0. Update on a consumed bit, with fb = d4 ^ bit_in:
  - d0 <= fb
  - d1 <= d0
  - d2 <= d1 ^ fb
  - d3 <= d2
  - d4 <= d3
- FSM states IDLE, DATA, CRC, DONE. A 4-bit bit counter is cleared on every state entry.
- IDLE:
  - start -> DATA; LFSR <= 5'b11111; field shift register <= 0; counter <= 0.
  - bit_valid is ignored in IDLE.
- DATA:
  - On each bit_valid: LFSR updates; field <= {field[9:0], bit_in}; counter++.
  - The first bit received lands in field[10].
  - On the 11th consumed bit (counter == 10 and bit_valid) -> CRC, counter cleared.
- CRC:
  - On each bit_valid: LFSR updates; field holds.
  - On the 5th consumed bit -> DONE.
  - On that same edge, the next-state LFSR value is latched into residual, its compare into crc_ok, and field into addr/endp.
- DONE:
  - done = 1; outputs stable; bit_valid ignored.
  - rec -> IDLE; done drops the cycle after rec is sampled.
- Result latency: done asserts on the cycle after the edge that consumed the 16th bit.
- busy = 1 in DATA and CRC only.
- start while in DATA or CRC: aborts and restarts.
  - LFSR re-presets, counter clears, state -> DATA.
  - A bit_valid on the same cycle is discarded.
  - done never asserts for the aborted packet.
- start while in DONE without rec: ignored.
- start and rec together in DONE: go directly to DATA with re-preset; done drops.
- rst_n = 1, any state:
  - Next edge -> IDLE, LFSR = 5'b11111.
  - done = 0, busy = 0, crc_ok = 0, addr = 0, endp = 0, residual = 0.
- addr/endp/crc_ok/residual change only on DONE entry or reset. Between packets they hold the previous result.

Test Plan:
- Good token: start; field bits 1,0,1,0,0,0,0,0,0,1,0; CRC bits 0,0,0,0,1 -> done = 1, crc_ok = 1, residual = 5'b01100, addr = 7'b1010000, endp = 4'b0010.
- Corrupt last CRC bit (send 0,0,0,0,0) -> done = 1, crc_ok = 0, residual = 5'b01001, addr/endp as above.
- Same good token with bit_valid deasserted for 3 cycles between every bit -> identical result to the good-token case; busy high throughout; done exactly one cycle after the 16th valid bit.
- Hold rec low 10 cycles in DONE -> done and outputs stable. Pulse rec -> done = 0 next cycle, busy = 0. Then start a second good token -> second result is correct.
- Restart abort: start, 6 bits, then start again, then the full good token -> single done with crc_ok = 1, no intermediate done.
- Reset during CRC state (after 13 bits) -> next cycle busy = 0, done = 0, crc_ok = 0, addr = 0. Then a good token checks clean.
